// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronised rising-edge capture with round-robin single-consumer dispatch.
// Optional per-channel debounce filter enabled by defining EDGE_EVENT_ARBITER_DEBOUNCE_EN.
module edge_event_arbiter #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_event,
  input  logic [N_CH-1:0]         i_mask,
  input  logic                    i_ready,
  input  logic                    i_clr_overflow,
  output logic                    o_valid,
  output logic [$clog2(N_CH)-1:0] o_ch_id,
  output logic [N_CH-1:0]         o_pending,
  output logic [N_CH-1:0]         o_overflow
);
  localparam int CW = $clog2(N_CH);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t          state_q, state_d;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] raw, lvl, lvl_q, edg, elig, clr;
  logic [N_CH-1:0] pending_q, pending_d, ovf_q, ovf_d;
  logic [CW-1:0]   ch_q, ch_d, rr_q, rr_d, pick;
  logic            found, hs;
  int              idx;
  assign raw = sync_q[SYNC_STAGES-1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_event;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
`ifdef EDGE_EVENT_ARBITER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0]   cnt_q [N_CH];
  logic [DW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] filt_q, filt_d;
  // The filtered level only follows raw after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_comb begin
    filt_d = filt_q;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = '0;
      if (raw[c] != filt_q[c]) begin
        if (int'(cnt_q[c]) + 1 >= DEBOUNCE_CYC) filt_d[c] = raw[c];
        else cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q <= '0;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = raw;
`endif
  assign edg  = lvl & ~lvl_q;
  assign elig = pending_q & ~i_mask;
  assign hs   = (state_q == OFFER) & i_ready;
  assign clr  = hs ? (N_CH'(1) << ch_q) : '0;
  // A fresh edge beats a same-cycle handshake clear, and only an unserved pending bit overflows.
  assign pending_d = (pending_q & ~clr) | edg;
  assign ovf_d     = (i_clr_overflow ? '0 : ovf_q) | (edg & pending_q & ~clr);
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_q) + i) % N_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    if (state_q == IDLE) begin
      state_d = found ? OFFER : IDLE;
      ch_d    = found ? pick : ch_q;
    end else if (i_ready) begin
      state_d = IDLE;
      rr_d    = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      ch_q      <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
    end
  end
  assign o_valid    = (state_q == OFFER);
  assign o_ch_id    = ch_q;
  assign o_pending  = pending_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vector table plus hand sequences for hold, overflow, mask, reset and debounce.
module tb_edge_event_arbiter;
`ifdef EDGE_EVENT_ARBITER_DEBOUNCE_EN
  localparam int DB = 3;
`else
  localparam int DB = 0;
`endif
  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_event = '0, i_mask = '0;
  logic       i_ready = 1'b0, i_clr_overflow = 1'b0;
  logic       o_valid;
  logic [1:0] o_ch_id;
  logic [3:0] o_pending, o_overflow;
  int         checks = 0, failures = 0;
  always #5 clk = ~clk;
  edge_event_arbiter dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_event(i_event), .i_mask(i_mask),
    .i_ready(i_ready), .i_clr_overflow(i_clr_overflow), .o_valid(o_valid),
    .o_ch_id(o_ch_id), .o_pending(o_pending), .o_overflow(o_overflow)
  );
  typedef struct {
    logic       rstn;
    logic [3:0] ev;
    logic       rdy;
    logic       val;
    logic [1:0] ch;
    logic [3:0] pend;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic rn, input logic [3:0] ev, input logic v, input logic [1:0] ch, input logic [3:0] pd);
    vec_t r;
    r.rstn = rn; r.ev = ev; r.rdy = 1'b1; r.val = v; r.ch = ch; r.pend = pd;
    tbl.push_back(r);
  endtask
  task automatic z(input logic [3:0] ev, input int n);
    for (int i = 0; i < n; i++) add(1'b1, ev, 1'b0, 2'd0, 4'b0000);
  endtask
  task automatic do_reset();
    @(negedge clk) i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask
  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = o_valid;
    end
  endtask
  bit ok;
  int lat;
  initial begin
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000);
    add(1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000);
    z(4'b0100, 2 + DB);
    add(1'b1, 4'b0100, 1'b0, 2'd0, 4'b0100);
    add(1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100);
    add(1'b1, 4'b0100, 1'b0, 2'd0, 4'b0000);
    z(4'b0000, 3 + DB);
    add(1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000);
    add(1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000);
    z(4'b1011, 2 + DB);
    add(1'b1, 4'b1011, 1'b0, 2'd0, 4'b1011);
    add(1'b1, 4'b1011, 1'b1, 2'd0, 4'b1011);
    add(1'b1, 4'b1011, 1'b0, 2'd0, 4'b1010);
    add(1'b1, 4'b1011, 1'b1, 2'd1, 4'b1010);
    add(1'b1, 4'b1011, 1'b0, 2'd0, 4'b1000);
    add(1'b1, 4'b1011, 1'b1, 2'd3, 4'b1000);
    add(1'b1, 4'b1011, 1'b0, 2'd0, 4'b0000);
    z(4'b0000, 3 + DB);
    z(4'b1001, 2 + DB);
    add(1'b1, 4'b1001, 1'b0, 2'd0, 4'b1001);
    add(1'b1, 4'b1001, 1'b1, 2'd0, 4'b1001);
    add(1'b1, 4'b1001, 1'b0, 2'd0, 4'b1000);
    add(1'b1, 4'b1001, 1'b1, 2'd3, 4'b1000);
    add(1'b1, 4'b1001, 1'b0, 2'd0, 4'b0000);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      i_rst_n = tbl[i].rstn; i_event = tbl[i].ev; i_ready = tbl[i].rdy;
      @(posedge clk) #1;
      chk($sformatf("row%0d_valid", i), 32'(o_valid), 32'(tbl[i].val));
      chk($sformatf("row%0d_pending", i), 32'(o_pending), 32'(tbl[i].pend));
      chk($sformatf("row%0d_overflow", i), 32'(o_overflow), 32'h0);
      if (tbl[i].val) chk($sformatf("row%0d_ch", i), 32'(o_ch_id), 32'(tbl[i].ch));
    end
    // held offer, overflow on second edge, overflow clear
    i_event = '0; i_ready = 1'b0; i_mask = '0;
    do_reset();
    @(negedge clk) i_event = 4'b0010;
    wait_valid(20, ok);
    chk("hold_offer", 32'(ok), 32'h1);
    chk("hold_ch", 32'(o_ch_id), 32'h1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) i_event = 4'b0000;
      if (i == 7) i_event = 4'b0010;
      chk($sformatf("hold_valid%0d", i), 32'({o_valid, o_ch_id}), 32'h5);
    end
    @(negedge clk);
    chk("ovf_set", 32'(o_overflow), 32'h2);
    chk("ovf_pending", 32'(o_pending), 32'h2);
    i_clr_overflow = 1'b1;
    @(negedge clk) i_clr_overflow = 1'b0;
    chk("ovf_clear", 32'(o_overflow), 32'h0);
    i_ready = 1'b1;
    @(negedge clk) i_ready = 1'b0;
    chk("hold_release_valid", 32'(o_valid), 32'h0);
    chk("hold_release_pending", 32'(o_pending), 32'h0);
    // masked channel latches but is not offered
    i_event = 4'b0001; i_mask = 4'b0001; i_ready = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    chk("mask_pending", 32'(o_pending), 32'h1);
    chk("mask_valid", 32'(o_valid), 32'h0);
    i_mask = 4'b0000;
    @(negedge clk);
    chk("unmask_offer", 32'({o_valid, o_ch_id}), 32'h4);
    @(negedge clk);
    chk("unmask_served", 32'({o_valid, o_pending}), 32'h0);
    // asynchronous reset during an offer
    i_event = 4'b0100; i_ready = 1'b0;
    do_reset();
    wait_valid(20, ok);
    chk("pre_reset_offer", 32'(ok), 32'h1);
    @(negedge clk) #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'h0);
    chk("async_rst_pending", 32'(o_pending), 32'h0);
    chk("async_rst_overflow", 32'(o_overflow), 32'h0);
    i_event = 4'b1101;
    @(negedge clk) i_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_pending", 32'(o_pending), 32'hd);
    chk("post_rst_offer", 32'({o_valid, o_ch_id}), 32'h4);
    chk("post_rst_overflow", 32'(o_overflow), 32'h0);
`ifdef EDGE_EVENT_ARBITER_DEBOUNCE_EN
    i_event = '0; i_ready = 1'b0;
    do_reset();
    @(negedge clk) i_event = 4'b0100;
    repeat (2) @(negedge clk);
    i_event = 4'b0000;
    repeat (10) @(negedge clk);
    chk("glitch_filtered", 32'(o_pending), 32'h0);
    i_event = 4'b0100;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      if (o_pending[2] && lat < 0) lat = i;
    end
    chk("debounce_latency", 32'(lat), 32'd5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
